// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
//   Bimodal branch predictor: 16 x 2-bit saturating counters indexed by
//   PC[5:2]. The fetch stage reads a prediction combinationally. The execute
//   stage writes back resolved outcomes and receives a registered
//   mispredict/redirect pulse.
//
//   Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
//
// Ports
//   clk            in   1   rising-edge clock
//   reset          in   1   asynchronous, active-high; clears all state
//   pc_if          in  64   fetch PC being predicted
//   predict_taken  out  1   combinational prediction for pc_if
//   update_valid   in   1   a branch resolved this cycle
//   update_pc      in  64   PC of the resolved branch
//   update_taken   in   1   actual outcome
//   update_pred    in   1   prediction carried down with the branch
//   mispredict     out  1   registered one-cycle pulse on a wrong prediction
//   redirect_taken out  1   registered copy of the last resolved outcome
//   branch_count   out 32   (BP_STATS_EN only) resolved-branch count
//   miss_count     out 32   (BP_STATS_EN only) mispredicted-branch count
//
// Configuration macro: BP_STATS_EN adds the two statistics counters.
// ---------------------------------------------------------------------------
module branch_predictor (
  input  logic        clk,
  input  logic        reset,
  input  logic [63:0] pc_if,
  output logic        predict_taken,
  input  logic        update_valid,
  input  logic [63:0] update_pc,
  input  logic        update_taken,
  input  logic        update_pred,
  output logic        mispredict,
  output logic        redirect_taken
`ifdef BP_STATS_EN
  ,
  output logic [31:0] branch_count,
  output logic [31:0] miss_count
`endif
);

  logic [1:0] r_table [16];
  logic       r_mispredict;
  logic       r_redirect_taken;

  logic [3:0] w_fetch_idx;
  logic [3:0] w_upd_idx;
  logic [1:0] w_cur;
  logic [1:0] w_new;
  logic       w_miss;
  logic       w_unused;

  assign w_fetch_idx = pc_if[5:2];
  assign w_upd_idx   = update_pc[5:2];

  // Only PC[5:2] participates in indexing; other bits alias freely.
  assign w_unused = ^{pc_if[63:6], pc_if[1:0], update_pc[63:6], update_pc[1:0]};

  // Read straight from the table, so a same-cycle update to the same entry
  // is not visible until the following cycle.
  assign predict_taken = r_table[w_fetch_idx][1];

  // Saturating step for the entry being updated.
  assign w_cur = r_table[w_upd_idx];
  always_comb begin
    w_new = w_cur;
    if (update_taken) begin
      if (w_cur != 2'b11) w_new = w_cur + 2'd1;
    end else begin
      if (w_cur != 2'b00) w_new = w_cur - 2'd1;
    end
  end

  assign w_miss = update_valid && (update_taken != update_pred);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) r_table[i] <= 2'b01;
    end else if (update_valid) begin
      r_table[w_upd_idx] <= w_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mispredict     <= 1'b0;
      r_redirect_taken <= 1'b0;
    end else begin
      r_mispredict <= w_miss;
      if (update_valid) r_redirect_taken <= update_taken;
    end
  end

  assign mispredict     = r_mispredict;
  assign redirect_taken = r_redirect_taken;

`ifdef BP_STATS_EN
  logic [31:0] r_branch_count;
  logic [31:0] r_miss_count;

  // Both counters wrap naturally at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_branch_count <= 32'd0;
      r_miss_count   <= 32'd0;
    end else begin
      if (update_valid) r_branch_count <= r_branch_count + 32'd1;
      if (w_miss)       r_miss_count   <= r_miss_count + 32'd1;
    end
  end

  assign branch_count = r_branch_count;
  assign miss_count   = r_miss_count;
`endif

endmodule

// File: tb/tb_branch_predictor.sv
// ---------------------------------------------------------------------------
// tb_branch_predictor
//   Directed-vector bench for branch_predictor. Each scenario task drives
//   stimulus and compares outputs against hand-computed values.
// ---------------------------------------------------------------------------
module tb_branch_predictor;

  logic        clk;
  logic        reset;
  logic [63:0] pc_if;
  logic        predict_taken;
  logic        update_valid;
  logic [63:0] update_pc;
  logic        update_taken;
  logic        update_pred;
  logic        mispredict;
  logic        redirect_taken;
`ifdef BP_STATS_EN
  logic [31:0] branch_count;
  logic [31:0] miss_count;
`endif

  int n_vec  = 0;
  int n_miss = 0;
  int cycle  = 0;

  branch_predictor dut (
    .clk            (clk),
    .reset          (reset),
    .pc_if          (pc_if),
    .predict_taken  (predict_taken),
    .update_valid   (update_valid),
    .update_pc      (update_pc),
    .update_taken   (update_taken),
    .update_pred    (update_pred),
    .mispredict     (mispredict),
    .redirect_taken (redirect_taken)
`ifdef BP_STATS_EN
    ,
    .branch_count   (branch_count),
    .miss_count     (miss_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and land 1ns after it; log the transaction.
  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
    $display("cyc %0d: upd_v=%0b upd_pc=%h tk=%0b pr=%0b | pc_if=%h pred=%0b misp=%0b redir=%0b",
             cycle, update_valid, update_pc, update_taken, update_pred,
             pc_if, predict_taken, mispredict, redirect_taken);
  endtask

  task automatic drive_upd(input logic v, input logic [63:0] pc,
                           input logic tk, input logic pr);
    update_valid = v;
    update_pc    = pc;
    update_taken = tk;
    update_pred  = pr;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_upd(1'b0, 64'h0, 1'b0, 1'b0);
    pc_if = 64'h40;
    step();
    step();
    reset = 1'b0;
    step();
    n_vec++;
    if (predict_taken !== 1'b0) begin
      n_miss++; $display("FAIL reset_pred_0x40: got %b expected 0", predict_taken);
    end
    n_vec++;
    if (mispredict !== 1'b0) begin
      n_miss++; $display("FAIL reset_mispredict: got %b expected 0", mispredict);
    end
    n_vec++;
    if (redirect_taken !== 1'b0) begin
      n_miss++; $display("FAIL reset_redirect: got %b expected 0", redirect_taken);
    end
    for (int i = 0; i < 16; i++) begin
      pc_if = 64'(i) << 2;
      #1;
      n_vec++;
      if (predict_taken !== 1'b0) begin
        n_miss++; $display("FAIL reset_index_%0d: got %b expected 0", i, predict_taken);
      end
    end
  endtask

  task automatic test_first_update();
    pc_if = 64'h40;
    drive_upd(1'b1, 64'h40, 1'b1, 1'b0);
    step();
    drive_upd(1'b0, 64'h0, 1'b0, 1'b0);
    #1;
    n_vec++;
    if (mispredict !== 1'b1) begin
      n_miss++; $display("FAIL first_mispredict: got %b expected 1", mispredict);
    end
    n_vec++;
    if (redirect_taken !== 1'b1) begin
      n_miss++; $display("FAIL first_redirect: got %b expected 1", redirect_taken);
    end
    n_vec++;
    if (predict_taken !== 1'b1) begin
      n_miss++; $display("FAIL first_pred_0x40: got %b expected 1", predict_taken);
    end
    step();
    n_vec++;
    if (mispredict !== 1'b0) begin
      n_miss++; $display("FAIL first_pulse_end: got %b expected 0", mispredict);
    end
    n_vec++;
    if (redirect_taken !== 1'b1) begin
      n_miss++; $display("FAIL first_redirect_hold: got %b expected 1", redirect_taken);
    end
  endtask

  task automatic test_saturate_high();
    // Entry 1: 01 -> 10 -> 11 -> 11 -> 11, predictions made as taken.
    pc_if = 64'h44;
    for (int k = 0; k < 4; k++) begin
      drive_upd(1'b1, 64'h44, 1'b1, 1'b1);
      step();
      n_vec++;
      if (predict_taken !== 1'b1 || mispredict !== 1'b0) begin
        n_miss++;
        $display("FAIL sat_taken_%0d: got pred=%b misp=%b expected pred=1 misp=0",
                 k, predict_taken, mispredict);
      end
    end
    // 11 -> 10: still predicts taken, and the predicted-taken branch missed.
    drive_upd(1'b1, 64'h44, 1'b0, 1'b1);
    step();
    n_vec++;
    if (predict_taken !== 1'b1) begin
      n_miss++; $display("FAIL sat_down_pred: got %b expected 1", predict_taken);
    end
    n_vec++;
    if (mispredict !== 1'b1 || redirect_taken !== 1'b0) begin
      n_miss++;
      $display("FAIL sat_down_misp: got misp=%b redir=%b expected misp=1 redir=0",
               mispredict, redirect_taken);
    end
    // 10 -> 01 proves the previous value was 10 (not 11 or a wrapped value).
    drive_upd(1'b1, 64'h44, 1'b0, 1'b0);
    step();
    drive_upd(1'b0, 64'h0, 1'b0, 1'b0);
    n_vec++;
    if (predict_taken !== 1'b0 || mispredict !== 1'b0) begin
      n_miss++;
      $display("FAIL sat_down2: got pred=%b misp=%b expected pred=0 misp=0",
               predict_taken, mispredict);
    end
  endtask

  task automatic test_saturate_low();
    // Entry 5: 01 -> 00 -> 00, then taken -> 01 (predict 0) -> 10 (predict 1).
    pc_if = 64'h54;
    drive_upd(1'b1, 64'h54, 1'b0, 1'b0);
    step();
    step();
    drive_upd(1'b1, 64'h54, 1'b1, 1'b0);
    step();
    n_vec++;
    if (predict_taken !== 1'b0) begin
      n_miss++; $display("FAIL low_floor: got %b expected 0", predict_taken);
    end
    step();
    drive_upd(1'b0, 64'h0, 1'b0, 1'b0);
    n_vec++;
    if (predict_taken !== 1'b1) begin
      n_miss++; $display("FAIL low_recover: got %b expected 1", predict_taken);
    end
    // Update with valid low must leave the table alone.
    update_pc = 64'h54; update_taken = 1'b0;
    step();
    n_vec++;
    if (predict_taken !== 1'b1 || mispredict !== 1'b0) begin
      n_miss++;
      $display("FAIL idle_no_change: got pred=%b misp=%b expected pred=1 misp=0",
               predict_taken, mispredict);
    end
  endtask

  task automatic test_no_bypass();
    pc_if = 64'h48;
    drive_upd(1'b1, 64'h48, 1'b1, 1'b0);
    #1;
    n_vec++;
    if (predict_taken !== 1'b0) begin
      n_miss++; $display("FAIL bypass_same_cycle: got %b expected 0", predict_taken);
    end
    step();
    drive_upd(1'b0, 64'h0, 1'b0, 1'b0);
    n_vec++;
    if (predict_taken !== 1'b1) begin
      n_miss++; $display("FAIL bypass_next_cycle: got %b expected 1", predict_taken);
    end
  endtask

  task automatic test_back_to_back();
    drive_upd(1'b1, 64'h4C, 1'b1, 1'b0);
    step();
    drive_upd(1'b1, 64'h4C, 1'b0, 1'b1);
    n_vec++;
    if (mispredict !== 1'b1 || redirect_taken !== 1'b1) begin
      n_miss++;
      $display("FAIL b2b_first: got misp=%b redir=%b expected misp=1 redir=1",
               mispredict, redirect_taken);
    end
    step();
    drive_upd(1'b0, 64'h0, 1'b0, 1'b0);
    n_vec++;
    if (mispredict !== 1'b1 || redirect_taken !== 1'b0) begin
      n_miss++;
      $display("FAIL b2b_second: got misp=%b redir=%b expected misp=1 redir=0",
               mispredict, redirect_taken);
    end
    step();
    n_vec++;
    if (mispredict !== 1'b0) begin
      n_miss++; $display("FAIL b2b_end: got %b expected 0", mispredict);
    end
  endtask

  task automatic test_aliasing();
    // Entry 4 written through a PC with high bits set, read through 0x10.
    drive_upd(1'b1, 64'hFFFF_0000_0000_0053, 1'b1, 1'b1);
    step();
    drive_upd(1'b0, 64'h0, 1'b0, 1'b0);
    pc_if = 64'h10;
    #1;
    n_vec++;
    if (predict_taken !== 1'b1) begin
      n_miss++; $display("FAIL alias_pred: got %b expected 1", predict_taken);
    end
  endtask

  task automatic test_reset_midop();
    // Entry 6 (0x58): first update produces a pulse, second is cut by reset.
    pc_if = 64'h58;
    drive_upd(1'b1, 64'h58, 1'b1, 1'b0);
    step();
    n_vec++;
    if (mispredict !== 1'b1) begin
      n_miss++; $display("FAIL midop_pre_pulse: got %b expected 1", mispredict);
    end
    #2 reset = 1'b1;
    #1;
    n_vec++;
    if (mispredict !== 1'b0 || redirect_taken !== 1'b0) begin
      n_miss++;
      $display("FAIL midop_async_clear: got misp=%b redir=%b expected 0 0",
               mispredict, redirect_taken);
    end
    step();
    reset = 1'b0;
    drive_upd(1'b0, 64'h0, 1'b0, 1'b0);
    n_vec++;
    if (predict_taken !== 1'b0 || mispredict !== 1'b0) begin
      n_miss++;
      $display("FAIL midop_entry: got pred=%b misp=%b expected pred=0 misp=0",
               predict_taken, mispredict);
    end
    step();
    n_vec++;
    if (mispredict !== 1'b0) begin
      n_miss++; $display("FAIL midop_after_release: got %b expected 0", mispredict);
    end
    pc_if = 64'h40;
    #1;
    n_vec++;
    if (predict_taken !== 1'b0) begin
      n_miss++; $display("FAIL midop_table_cleared: got %b expected 0", predict_taken);
    end
  endtask

`ifdef BP_STATS_EN
  task automatic test_stats();
    n_vec++;
    if (branch_count !== 32'd0 || miss_count !== 32'd0) begin
      n_miss++;
      $display("FAIL stats_reset: got br=%h miss=%h expected 0 0", branch_count, miss_count);
    end
    drive_upd(1'b1, 64'h60, 1'b1, 1'b0); step();
    drive_upd(1'b1, 64'h60, 1'b1, 1'b1); step();
    drive_upd(1'b1, 64'h60, 1'b0, 1'b1); step();
    drive_upd(1'b0, 64'h0, 1'b0, 1'b0);
    n_vec++;
    if (branch_count !== 32'd3 || miss_count !== 32'd2) begin
      n_miss++;
      $display("FAIL stats_counts: got br=%0d miss=%0d expected 3 2", branch_count, miss_count);
    end
    dut.r_branch_count = 32'hFFFF_FFFE;
    dut.r_miss_count   = 32'hFFFF_FFFF;
    drive_upd(1'b1, 64'h60, 1'b1, 1'b1); step();
    n_vec++;
    if (branch_count !== 32'hFFFF_FFFF || miss_count !== 32'hFFFF_FFFF) begin
      n_miss++;
      $display("FAIL stats_near_wrap: got br=%h miss=%h expected ffffffff ffffffff",
               branch_count, miss_count);
    end
    drive_upd(1'b1, 64'h60, 1'b0, 1'b1); step();
    drive_upd(1'b0, 64'h0, 1'b0, 1'b0);
    n_vec++;
    if (branch_count !== 32'd0 || miss_count !== 32'd0) begin
      n_miss++;
      $display("FAIL stats_wrap: got br=%h miss=%h expected 0 0", branch_count, miss_count);
    end
  endtask
`endif

  initial begin
    reset = 1'b1;
    pc_if = 64'h0;
    drive_upd(1'b0, 64'h0, 1'b0, 1'b0);
    test_reset();
    test_first_update();
    test_saturate_high();
    test_saturate_low();
    test_no_bypass();
    test_back_to_back();
    test_aliasing();
    test_reset_midop();
`ifdef BP_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
